bram_table_arbiter: RTL and testbench
=====================================

# bram_table_arbiter

Parametrised N-channel front end that lets several pipeline stages share the single port of one BRAM table, generalising the one-owner/one-user BRAM binding used across the PCIe datapath. It sits between N requesters and the `user` side of one `bram_interface_io` instance. It arbitrates round-robin among requesters, issues one command per cycle to the BRAM, and tracks in-flight reads through a latency-matched tag pipeline. Each read response is routed back to the channel that issued it.

## Interface
- `NUM_CH`, default 4: number of requester channels, 1..16.
- `ADDR_WIDTH`, default `BRAM_TABLE_IDX_WIDTH`: table index width.
- `DATA_WIDTH`, default 32: entry width.
- `RD_LATENCY`, default 2: BRAM cycles from `rd_en` to valid `rd_data`, 1..4.

Clock and reset are fixed: one clock; reset is asynchronous and active-high.

- `clk` input 1: sole clock.
- `rst` input 1: asynchronous, active-high reset.
- `req_addr` input `NUM_CH`×`ADDR_WIDTH`: per-channel address.
- `req_wr_data` input `NUM_CH`×`DATA_WIDTH`: per-channel write data.
- `req_rd_en` input `NUM_CH`: per-channel read request.
- `req_wr_en` input `NUM_CH`: per-channel write request.
- `req_gnt` output `NUM_CH`: one-hot grant; the request is accepted this cycle.
- `rsp_valid` output `NUM_CH`: one-hot; read data for this channel is on `rsp_data`.
- `rsp_data` output `DATA_WIDTH`: shared read-response bus.
- `bram` `bram_interface_io.user`: `addr`, `wr_data`, `rd_en`, `wr_en` out; `rd_data` in.

## Operation
- **Active channel:** channel i is active when `req_rd_en[i] | req_wr_en[i]`.
- **Holding rule:** a requester holds addr, data and enables stable until it sees `req_gnt[i]`. Dropping a request before grant is legal; the request is then simply not issued.
- **Arbitration:** combinational round-robin starting from pointer `rr_ptr`, which has width max(1, $clog2(NUM_CH)) and resets to 0.
  - The first active channel at or after `rr_ptr`, modulo `NUM_CH`, is granted.
  - On any grant, `rr_ptr` becomes granted index + 1, wrapping `NUM_CH`-1 → 0.
  - With no grant, `rr_ptr` holds.
- **Command path:** the granted channel's addr, wr_data, rd_en and wr_en drive `bram`. With no grant, `bram.rd_en` = `bram.wr_en` = 0 and addr/wr_data hold their last value.
- **Read and write together:** `rd_en` and `wr_en` may both be set on one channel; both are issued together. The returned data follows the BRAM's read-during-write behaviour; the arbiter does not alter it.
- **Tag pipeline:** an accepted read pushes {valid=1, channel id} into a shift pipeline of depth `RD_LATENCY`. Cycles with no accepted read push valid=0.
- **Response:** at the pipeline head, `rsp_valid[id]` = head.valid and `rsp_data` = `bram.rd_data`.
- **Writes:** writes produce no response.
- **No back-pressure:** requesters must accept `rsp_valid` whenever it is asserted.
- **NUM_CH=1:** degenerates to a pass-through plus tag pipeline. `req_gnt[0]` follows channel activity and `rr_ptr` stays 0.

## Timing
- **Grant:** same cycle as the request (combinational). Throughput is one command per cycle in total.
- **Read latency:** a read granted in cycle T gives `rsp_valid` in cycle T+`RD_LATENCY`.
- **Starvation bound:** a continuously active channel is granted within `NUM_CH` cycles.
- **Reset values:** `rr_ptr`=0, tag pipeline all invalid, `rsp_valid`=0, `rsp_data`=`bram.rd_data`, `bram.rd_en`=`bram.wr_en`=0, `bram.addr`=0, `bram.wr_data`=0.
- **Reset mid-operation:** all in-flight reads are discarded and no `rsp_valid` is emitted for them. The first grant after reset release goes to the lowest active channel.
- **`rsp_valid` is never asserted without a matching earlier grant.** At most one `rsp_valid` bit is high per cycle.

## Configuration
- **`BRAM_ARB_OUT_REG_EN` defined:**
  - The command to `bram` (addr, wr_data, rd_en, wr_en) is registered, which eases timing to far BRAM tables.
  - The grant remains same-cycle.
  - The tag pipeline depth becomes `RD_LATENCY`+1, so a read granted at T responds at T+`RD_LATENCY`+1.
  - The command registers reset to 0.
- **Undefined:** the command is combinational from the arbiter, as described above.

## Structure
- **Shared package `bram_arb_pkg`:**
  - Typedef `bram_tag_t` {valid, ch_id}.
  - Constant `BRAM_ARB_MAX_CH` = 16.
  - Function `rr_next(ptr, idx, n)`.
- **Dependencies:** `BRAM_TABLE_IDX_WIDTH` continues to come from `pcie_consts.sv`.
- **Sub-module `rr_arbiter`:** parameter `NUM_CH`; inputs `clk`, `rst`, `req[NUM_CH]`; outputs one-hot `gnt` and `gnt_idx`; owns `rr_ptr`. It is reusable by other shared-table front ends.
- **Top level:** the tag pipeline and command mux stay in `bram_table_arbiter`.

## Test plan
- **Single read, NUM_CH=4, RD_LATENCY=2:** ch2 reads addr 0x15 preloaded with 0xDEADBEEF at T → `req_gnt`=4'b0100 at T; `rsp_valid`=4'b0100 with `rsp_data`=0xDEADBEEF at T+2, nothing else.
- **All four channels reading continuously from reset:** grant order ch0, ch1, ch2, ch3, ch0…; each channel gets exactly 25 of 100 grants; responses arrive in grant order, 2 cycles late.
- **Write then read:** ch1 writes 0x12345678 to addr 7, then ch3 reads addr 7 the next cycle → ch3 sees 0x12345678; no `rsp_valid` for the write.
- **Reset mid-flight:** `rst` asserted one cycle after a ch0 read grant → no `rsp_valid` ever appears for it; after release `rr_ptr`=0 and ch0 wins against ch1.
- **`BRAM_ARB_OUT_REG_EN` defined:** repeat the single-read scenario → `bram.rd_en` high at T+1; response at T+3.
- **NUM_CH=1, back-to-back reads of addrs 0..7:** eight `rsp_valid` pulses on consecutive cycles starting 2 cycles after the first read, with data matching the preload.

Source files
------------

// File: rtl/bram_table_arbiter_pkg.sv
// Shared types and helpers for BRAM table arbitration front ends.
package bram_arb_pkg;

  // Largest channel count any arbiter instance may be built with.
  localparam int BRAM_ARB_MAX_CH = 16;

  // Width of a channel id, sized to address BRAM_ARB_MAX_CH channels.
  localparam int BRAM_ARB_CH_ID_W = $clog2(BRAM_ARB_MAX_CH);

  // One entry of the in-flight read tag pipeline.
  typedef struct packed {
    logic                        valid;
    logic [BRAM_ARB_CH_ID_W-1:0] ch_id;
  } bram_tag_t;

  // Channel index that lies idx positions after ptr in a ring of n
  // channels. ptr < n and idx <= n, so one subtraction wraps it.
  function automatic logic [BRAM_ARB_CH_ID_W-1:0] rr_next(
    input logic [BRAM_ARB_CH_ID_W-1:0] ptr,
    input logic [BRAM_ARB_CH_ID_W:0]   idx,
    input logic [BRAM_ARB_CH_ID_W:0]   n
  );
    int sum;
    sum = int'(ptr) + int'(idx);
    if (sum >= int'(n)) begin
      sum = sum - int'(n);
    end
    return BRAM_ARB_CH_ID_W'(sum);
  endfunction

endpackage : bram_arb_pkg

// File: rtl/pcie_consts.sv
// PCIe datapath constants shared by the table front ends.
package pcie_consts;

  // Index width of the shared BRAM lookup tables.
  localparam int BRAM_TABLE_IDX_WIDTH = 8;

endpackage : pcie_consts

// File: rtl/bram_table_arbiter_if.sv
// Bus interfaces for the shared BRAM table: the requester side of the
// arbiter and the single-port BRAM binding itself.

interface bram_arb_req_if #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] req_wr_data;
  logic [NUM_CH-1:0]                 req_rd_en;
  logic [NUM_CH-1:0]                 req_wr_en;
  logic [NUM_CH-1:0]                 req_gnt;
  logic [NUM_CH-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]             rsp_data;

  // Requesters drive commands and observe grants and responses.
  modport master (
    output req_addr, req_wr_data, req_rd_en, req_wr_en,
    input  req_gnt, rsp_valid, rsp_data
  );

  // The arbiter consumes commands and produces grants and responses.
  modport slave (
    input  req_addr, req_wr_data, req_rd_en, req_wr_en,
    output req_gnt, rsp_valid, rsp_data
  );
endinterface : bram_arb_req_if

interface bram_interface_io #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  // The table user issues commands and receives read data.
  modport user (
    output addr, wr_data, rd_en, wr_en,
    input  rd_data
  );

  // The table owner (the BRAM) executes commands and returns read data.
  modport owner (
    input  addr, wr_data, rd_en, wr_en,
    output rd_data
  );
endinterface : bram_interface_io

// File: rtl/bram_table_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered rotating priority pointer.
// Reusable by any shared-table front end that needs one grant per cycle.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_cand;
  logic             w_found;

  // Walk the ring starting at the pointer and grant the first active channel.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    gnt     = '0;
    gnt_idx = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      w_cand = PTR_W'(rr_next(BRAM_ARB_CH_ID_W'(r_ptr),
                              (BRAM_ARB_CH_ID_W+1)'(off),
                              (BRAM_ARB_CH_ID_W+1)'(NUM_CH)));
      if (!w_found && req[w_cand]) begin
        w_found      = 1'b1;
        gnt_idx      = w_cand;
        gnt[w_cand]  = 1'b1;
      end
    end
  end

  // Move priority to the channel just after the winner; hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= PTR_W'(rr_next(BRAM_ARB_CH_ID_W'(gnt_idx),
                              (BRAM_ARB_CH_ID_W+1)'(1),
                              (BRAM_ARB_CH_ID_W+1)'(NUM_CH)));
    end
  end

endmodule : rr_arbiter

// File: rtl/bram_table_arbiter.sv
// N-channel front end sharing one BRAM table port among pipeline stages.
// Round-robin grants one command per cycle; a latency-matched tag pipeline
// routes each read response back to the channel that issued it.
// Optional macro BRAM_ARB_OUT_REG_EN registers the BRAM command, adding
// one cycle of read latency while keeping the grant same-cycle.
module bram_table_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = pcie_consts::BRAM_TABLE_IDX_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  bram_arb_req_if.slave    req_if,
  bram_interface_io.user   bram
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef BRAM_ARB_OUT_REG_EN
  localparam int TAG_DEPTH = RD_LATENCY + 1;
`else
  localparam int TAG_DEPTH = RD_LATENCY;
`endif

  logic [NUM_CH-1:0]     w_active;
  logic [NUM_CH-1:0]     w_gnt;
  logic [PTR_W-1:0]      w_gntIdx;
  logic                  w_any;
  logic [ADDR_WIDTH-1:0] w_selAddr;
  logic [DATA_WIDTH-1:0] w_selWrData;
  logic                  w_selRd;
  logic                  w_selWr;
  logic [ADDR_WIDTH-1:0] r_cmdAddr;
  logic [DATA_WIDTH-1:0] r_cmdWrData;
  bram_tag_t             w_pushTag;
  bram_tag_t             w_head;
  bram_tag_t             r_tagPipe [TAG_DEPTH];
  logic [NUM_CH-1:0]     w_rspValid;

  assign w_active = req_if.req_rd_en | req_if.req_wr_en;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rrArbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (w_active),
    .gnt     (w_gnt),
    .gnt_idx (w_gntIdx)
  );

  assign req_if.req_gnt = w_gnt;
  assign w_any          = |w_gnt;

  // The winning channel's command fields; enables are forced low when idle.
  always_comb begin
    w_selAddr   = req_if.req_addr[w_gntIdx];
    w_selWrData = req_if.req_wr_data[w_gntIdx];
    w_selRd     = w_any & req_if.req_rd_en[w_gntIdx];
    w_selWr     = w_any & req_if.req_wr_en[w_gntIdx];
  end

`ifdef BRAM_ARB_OUT_REG_EN
  logic r_cmdRd;
  logic r_cmdWr;

  // Register the whole command so far tables see a flop-to-flop path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmdAddr   <= '0;
      r_cmdWrData <= '0;
      r_cmdRd     <= 1'b0;
      r_cmdWr     <= 1'b0;
    end else begin
      r_cmdRd <= w_selRd;
      r_cmdWr <= w_selWr;
      if (w_any) begin
        r_cmdAddr   <= w_selAddr;
        r_cmdWrData <= w_selWrData;
      end
    end
  end

  assign bram.addr    = r_cmdAddr;
  assign bram.wr_data = r_cmdWrData;
  assign bram.rd_en   = r_cmdRd;
  assign bram.wr_en   = r_cmdWr;
`else
  // Remember the last issued address and data so idle cycles hold them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmdAddr   <= '0;
      r_cmdWrData <= '0;
    end else if (w_any) begin
      r_cmdAddr   <= w_selAddr;
      r_cmdWrData <= w_selWrData;
    end
  end

  assign bram.addr    = w_any ? w_selAddr   : r_cmdAddr;
  assign bram.wr_data = w_any ? w_selWrData : r_cmdWrData;
  assign bram.rd_en   = w_selRd;
  assign bram.wr_en   = w_selWr;
`endif

  // Tag for this cycle: valid only when a read was actually accepted.
  always_comb begin
    w_pushTag.valid = w_selRd;
    w_pushTag.ch_id = BRAM_ARB_CH_ID_W'(w_gntIdx);
  end

  // Shift tags so each one reaches the head exactly when its data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        r_tagPipe[i] <= '0;
      end
    end else begin
      r_tagPipe[0] <= w_pushTag;
      for (int i = 1; i < TAG_DEPTH; i++) begin
        r_tagPipe[i] <= r_tagPipe[i-1];
      end
    end
  end

  assign w_head = r_tagPipe[TAG_DEPTH-1];

  // Decode the head tag into a one-hot response strobe.
  always_comb begin
    w_rspValid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rspValid[i] = w_head.valid && (w_head.ch_id == BRAM_ARB_CH_ID_W'(i));
    end
  end

  assign req_if.rsp_valid = w_rspValid;
  assign req_if.rsp_data  = bram.rd_data;

endmodule : bram_table_arbiter

// File: tb/tb_bram_table_arbiter.sv
// Directed bench for bram_table_arbiter: a 4-channel and a 1-channel
// instance, each attached to a 2-cycle read-first BRAM model.
// Honours BRAM_ARB_OUT_REG_EN by adding one cycle to expected latency.
module tb_bram_table_arbiter;

`ifdef BRAM_ARB_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testCount = 0;
  int   failCount = 0;
  int   grantCnt [4];

  always #5 clk = ~clk;

  bram_arb_req_if   #(.NUM_CH(4), .ADDR_WIDTH(8), .DATA_WIDTH(32)) reqIf ();
  bram_interface_io #(.ADDR_WIDTH(8), .DATA_WIDTH(32))             bramIf ();
  bram_arb_req_if   #(.NUM_CH(1), .ADDR_WIDTH(8), .DATA_WIDTH(32)) reqIf1 ();
  bram_interface_io #(.ADDR_WIDTH(8), .DATA_WIDTH(32))             bramIf1 ();

  bram_table_arbiter #(.NUM_CH(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(2)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .req_if (reqIf.slave),
    .bram   (bramIf.user)
  );

  bram_table_arbiter #(.NUM_CH(1), .ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(2)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .req_if (reqIf1.slave),
    .bram   (bramIf1.user)
  );

  function automatic logic [31:0] initVal(input logic [7:0] a);
    if (a == 8'h15) return 32'hDEADBEEF;
    return {16'hC0DE, 8'h00, a};
  endfunction

  // BRAM models: preloaded while reset is high, two registered read stages.
  logic [31:0] mem4 [256];
  logic [31:0] pipe4 [2];
  logic [31:0] mem1 [256];
  logic [31:0] pipe1 [2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem4[i] <= initVal(8'(i));
      pipe4[0] <= '0;
      pipe4[1] <= '0;
    end else begin
      if (bramIf.wr_en) mem4[bramIf.addr] <= bramIf.wr_data;
      if (bramIf.rd_en) pipe4[0] <= mem4[bramIf.addr];
      pipe4[1] <= pipe4[0];
    end
  end
  assign bramIf.rd_data = pipe4[1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= initVal(8'(i));
      pipe1[0] <= '0;
      pipe1[1] <= '0;
    end else begin
      if (bramIf1.wr_en) mem1[bramIf1.addr] <= bramIf1.wr_data;
      if (bramIf1.rd_en) pipe1[0] <= mem1[bramIf1.addr];
      pipe1[1] <= pipe1[0];
    end
  end
  assign bramIf1.rd_data = pipe1[1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic applyStimulus(input int ch, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic rd,
                               input logic wr);
    reqIf.req_addr[ch]    = addr;
    reqIf.req_wr_data[ch] = wdata;
    reqIf.req_rd_en[ch]   = rd;
    reqIf.req_wr_en[ch]   = wr;
  endtask

  task automatic clearAll();
    reqIf.req_rd_en  = '0;
    reqIf.req_wr_en  = '0;
    reqIf1.req_rd_en = '0;
    reqIf1.req_wr_en = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] expV;
    logic [3:0] g;
    reqIf.req_addr     = '0;
    reqIf.req_wr_data  = '0;
    reqIf1.req_addr    = '0;
    reqIf1.req_wr_data = '0;
    clearAll();
    rst = 1'b1;

    // Reset state
    tick();
    tick();
    settle();
    checkOutput("rst_gnt",      32'(reqIf.req_gnt),   32'h0);
    checkOutput("rst_rspValid", 32'(reqIf.rsp_valid), 32'h0);
    checkOutput("rst_rdEn",     32'(bramIf.rd_en),    32'h0);
    checkOutput("rst_wrEn",     32'(bramIf.wr_en),    32'h0);
    checkOutput("rst_addr",     32'(bramIf.addr),     32'h0);
    checkOutput("rst_wrData",   bramIf.wr_data,       32'h0);
    checkOutput("rst_rspValid1", 32'(reqIf1.rsp_valid), 32'h0);
    tick();
    rst = 1'b0;

    // Single read: ch2 reads 0x15
    applyStimulus(2, 8'h15, 32'h0, 1'b1, 1'b0);
    settle();
    checkOutput("single_gnt",  32'(reqIf.req_gnt), 32'h4);
`ifdef BRAM_ARB_OUT_REG_EN
    checkOutput("single_rdEnT", 32'(bramIf.rd_en), 32'h0);
`else
    checkOutput("single_rdEnT", 32'(bramIf.rd_en), 32'h1);
    checkOutput("single_addrT", 32'(bramIf.addr),  32'h15);
`endif
    tick();
    clearAll();
    settle();
`ifdef BRAM_ARB_OUT_REG_EN
    checkOutput("single_rdEnT1", 32'(bramIf.rd_en), 32'h1);
`else
    checkOutput("single_rdEnT1", 32'(bramIf.rd_en), 32'h0);
`endif
    checkOutput("single_addrHold", 32'(bramIf.addr), 32'h15);
    for (int c = 1; c <= LAT + 1; c++) begin
      expV = (c == LAT) ? 4'b0100 : 4'b0000;
      checkOutput($sformatf("single_rspValid_c%0d", c), 32'(reqIf.rsp_valid), 32'(expV));
      if (c == LAT) checkOutput("single_rspData", reqIf.rsp_data, 32'hDEADBEEF);
      tick();
      settle();
    end

    // Continuous reads by all four channels from reset
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) grantCnt[c] = 0;
    for (int n = 0; n < 100 + LAT; n++) begin
      if (n < 100) begin
        for (int c = 0; c < 4; c++) applyStimulus(c, 8'(8'h20 + c), 32'h0, 1'b1, 1'b0);
      end else begin
        clearAll();
      end
      settle();
      if (n < 100) begin
        g = reqIf.req_gnt;
        for (int c = 0; c < 4; c++) if (g[c]) grantCnt[c]++;
        checkOutput($sformatf("rr_gnt_n%0d", n), 32'(g), 32'(4'b0001 << (n % 4)));
      end
      if (n >= LAT) begin
        checkOutput($sformatf("rr_rspValid_n%0d", n), 32'(reqIf.rsp_valid),
                    32'(4'b0001 << ((n - LAT) % 4)));
        checkOutput($sformatf("rr_rspData_n%0d", n), reqIf.rsp_data,
                    initVal(8'(8'h20 + ((n - LAT) % 4))));
      end
      tick();
    end
    for (int c = 0; c < 4; c++)
      checkOutput($sformatf("rr_grantCount_ch%0d", c), 32'(grantCnt[c]), 32'd25);

    // Write then read: ch1 writes addr 7, ch3 reads it next cycle
    applyStimulus(1, 8'h07, 32'h12345678, 1'b0, 1'b1);
    settle();
    checkOutput("wr_gnt", 32'(reqIf.req_gnt), 32'h2);
`ifndef BRAM_ARB_OUT_REG_EN
    checkOutput("wr_wrEn",   32'(bramIf.wr_en), 32'h1);
    checkOutput("wr_wrData", bramIf.wr_data,    32'h12345678);
`endif
    tick();
    clearAll();
    applyStimulus(3, 8'h07, 32'h0, 1'b1, 1'b0);
    settle();
    checkOutput("rd_gnt", 32'(reqIf.req_gnt), 32'h8);
    tick();
    clearAll();
    settle();
    for (int c = 1; c <= LAT + 1; c++) begin
      expV = (c == LAT) ? 4'b1000 : 4'b0000;
      checkOutput($sformatf("wrrd_rspValid_c%0d", c), 32'(reqIf.rsp_valid), 32'(expV));
      if (c == LAT) checkOutput("wrrd_rspData", reqIf.rsp_data, 32'h12345678);
      tick();
      settle();
    end

    // Reset one cycle after a ch0 read grant
    tick();
    applyStimulus(0, 8'h30, 32'h0, 1'b1, 1'b0);
    settle();
    checkOutput("mid_gnt", 32'(reqIf.req_gnt), 32'h1);
    tick();
    clearAll();
    rst = 1'b1;
    settle();
    checkOutput("mid_rstRsp0", 32'(reqIf.rsp_valid), 32'h0);
    checkOutput("mid_rstRdEn", 32'(bramIf.rd_en), 32'h0);
    tick();
    settle();
    checkOutput("mid_rstRsp1", 32'(reqIf.rsp_valid), 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 8'h31, 32'h0, 1'b1, 1'b0);
    applyStimulus(1, 8'h32, 32'h0, 1'b1, 1'b0);
    settle();
    checkOutput("mid_gntAfterRst", 32'(reqIf.req_gnt), 32'h1);
    checkOutput("mid_rspAfterRst", 32'(reqIf.rsp_valid), 32'h0);
    tick();
    applyStimulus(0, 8'h31, 32'h0, 1'b0, 1'b0);
    settle();
    checkOutput("mid_gntCh1", 32'(reqIf.req_gnt), 32'h2);
    tick();
    clearAll();
    settle();
    for (int c = 2; c <= LAT + 2; c++) begin
      expV = (c == LAT) ? 4'b0001 : ((c == LAT + 1) ? 4'b0010 : 4'b0000);
      checkOutput($sformatf("mid_rspValid_c%0d", c), 32'(reqIf.rsp_valid), 32'(expV));
      if (c == LAT)     checkOutput("mid_rspData0", reqIf.rsp_data, 32'hC0DE0031);
      if (c == LAT + 1) checkOutput("mid_rspData1", reqIf.rsp_data, 32'hC0DE0032);
      tick();
      settle();
    end

    // Single channel: back-to-back reads of addresses 0..7
    tick();
    for (int n = 0; n < 8 + LAT + 1; n++) begin
      if (n < 8) begin
        reqIf1.req_addr[0]  = 8'(n);
        reqIf1.req_rd_en[0] = 1'b1;
      end else begin
        clearAll();
      end
      settle();
      if (n < 8) checkOutput($sformatf("one_gnt_n%0d", n), 32'(reqIf1.req_gnt), 32'h1);
      if (n >= LAT && n < LAT + 8) begin
        checkOutput($sformatf("one_rspValid_n%0d", n), 32'(reqIf1.rsp_valid), 32'h1);
        checkOutput($sformatf("one_rspData_n%0d", n), reqIf1.rsp_data, initVal(8'(n - LAT)));
      end else begin
        checkOutput($sformatf("one_rspIdle_n%0d", n), 32'(reqIf1.rsp_valid), 32'h0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule : tb_bram_table_arbiter
